// File: rtl/vga_word_fetcher.sv
// ============================================================================
// vga_word_fetcher : scans NUM_WORDS memory words and queues their low bytes
//                    in a show-ahead FIFO for the VGA character renderer.
// Optional feature macro: VGA_FETCH_CHECKSUM_EN (adds checksum output port).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_word_fetcher #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         NUM_WORDS  = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic [5:0]  char_index
`ifdef VGA_FETCH_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr_nxt;
  logic [5:0]  idx, idx_nxt;

  logic [13:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, push, pop;

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[31:8];

  assign full = (count == DEPTH_C);
  assign push = (state == S_CAPTURE) && !full;
  assign pop  = char_valid && char_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_addr <= BASE_ADDR;
      idx      <= 6'd0;
    end else begin
      state    <= state_nxt;
      mem_addr <= addr_nxt;
      idx      <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          addr_nxt  = BASE_ADDR;
          idx_nxt   = 6'd0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        // A full FIFO holds everything; the memory is simply re-read next cycle.
        if (!full) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            addr_nxt  = mem_addr + 8'd4;
            idx_nxt   = idx + 6'd1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_ISSUE) || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {idx, mem_rdata[7:0]};
  end

  assign char_valid = (count != '0);
  assign char_data  = char_valid ? fifo_mem[rd_ptr][7:0]  : 8'd0;
  assign char_index = char_valid ? fifo_mem[rd_ptr][13:8] : 6'd0;

`ifdef VGA_FETCH_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= 8'd0;
    end else if ((state == S_IDLE) && start) begin
      checksum <= 8'd0;
    end else if (push) begin
      checksum <= checksum + mem_rdata[7:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_word_fetcher.sv
// ============================================================================
// tb_vga_word_fetcher : directed self-checking bench for vga_word_fetcher.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_word_fetcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word at byte address a: 32'hAABBCC41 at 0, ...42 at 4, etc.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {24'hAABBCC, 8'h41 + {2'b00, a[7:2]}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: base 0, 4 words
  logic start_a = 1'b0, ready_a = 1'b0;
  logic busy_a, done_a, valid_a;
  logic [7:0] addr_a, data_a;
  logic [5:0] index_a;
  logic [31:0] rdata_a;
  assign rdata_a = mem_word(addr_a);
`ifdef VGA_FETCH_CHECKSUM_EN
  logic [7:0] csum_a;
`endif

  vga_word_fetcher #(.BASE_ADDR(8'h00), .NUM_WORDS(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_addr(addr_a), .mem_rdata(rdata_a), .char_valid(valid_a),
    .char_ready(ready_a), .char_data(data_a), .char_index(index_a)
`ifdef VGA_FETCH_CHECKSUM_EN
    , .checksum(csum_a)
`endif
  );

  // Instance B: base 0, 8 words, 4-deep FIFO
  logic start_b = 1'b0, ready_b = 1'b0;
  logic busy_b, done_b, valid_b;
  logic [7:0] addr_b, data_b;
  logic [5:0] index_b;
  logic [31:0] rdata_b;
  assign rdata_b = mem_word(addr_b);
`ifdef VGA_FETCH_CHECKSUM_EN
  logic [7:0] csum_b;
`endif

  vga_word_fetcher #(.BASE_ADDR(8'h00), .NUM_WORDS(8), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_addr(addr_b), .mem_rdata(rdata_b), .char_valid(valid_b),
    .char_ready(ready_b), .char_data(data_b), .char_index(index_b)
`ifdef VGA_FETCH_CHECKSUM_EN
    , .checksum(csum_b)
`endif
  );

  // Instance C: base F8, 3 words (address wrap)
  logic start_c = 1'b0, ready_c = 1'b0;
  logic busy_c, done_c, valid_c;
  logic [7:0] addr_c, data_c;
  logic [5:0] index_c;
  logic [31:0] rdata_c;
  assign rdata_c = mem_word(addr_c);
`ifdef VGA_FETCH_CHECKSUM_EN
  logic [7:0] csum_c;
`endif

  vga_word_fetcher #(.BASE_ADDR(8'hF8), .NUM_WORDS(3), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .mem_addr(addr_c), .mem_rdata(rdata_c), .char_valid(valid_c),
    .char_ready(ready_c), .char_data(data_c), .char_index(index_c)
`ifdef VGA_FETCH_CHECKSUM_EN
    , .checksum(csum_c)
`endif
  );

  initial begin
    int k, first, done_cyc, ndone;
    logic [7:0] exp_addr [3];
    logic [7:0] exp_byte [3];
    logic [7:0] last_addr;
    int na;

    // ---------------- reset and idle hold ----------------
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_addr",  32'(addr_a),  32'h00);
      check("idle_valid", 32'(valid_a), 32'h0);
      check("idle_busy",  32'(busy_a),  32'h0);
      check("idle_done",  32'(done_a),  32'h0);
    end
    check("idle_data",  32'(data_a),  32'h0);
    check("idle_index", 32'(index_a), 32'h0);

    // ---------------- 4-word scan, ready high ----------------
    start_a = 1'b1;                        // cycle 0
    k = 0; first = -1; done_cyc = -1; ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start_a = (c == 4);                  // start while busy must be ignored
      if (valid_a) begin
        if (first < 0) first = c;
        if (k < 4) begin
          check("a_data",  32'(data_a),  32'(8'h41 + 8'(k)));
          check("a_index", 32'(index_a), 32'(k));
        end
        k++;
      end
      if (done_a) begin
        ndone++;
        done_cyc = c;
`ifdef VGA_FETCH_CHECKSUM_EN
        check("a_checksum", 32'(csum_a), 32'h0A);
`endif
      end
    end
    start_a = 1'b0;
    check("a_first_valid_cycle", 32'(first), 32'd3);
    check("a_done_cycle", 32'(done_cyc), 32'd9);
    check("a_done_count", 32'(ndone), 32'd1);
    check("a_byte_count", 32'(k), 32'd4);

    // ---------------- reset mid-scan ----------------
    ready_a = 1'b0;
    start_a = 1'b1;                        // cycle 0
    for (int c = 1; c <= 5; c++) begin
      tick();
      start_a = 1'b0;
    end
    check("rst_pre_valid", 32'(valid_a), 32'h1);
    rst = 1'b1;                            // cycle 5, two pushes already made
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);
    check("rst_addr",  32'(addr_a),  32'h00);
    ndone = (done_a) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done_a) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("rescan_busy", 32'(busy_a), 32'h1);
    check("rescan_addr", 32'(addr_a), 32'h00);
    k = 0;
    for (int c = 0; c < 10 && k == 0; c++) begin
      tick();
      if (valid_a) begin
        check("rescan_data",  32'(data_a),  32'h41);
        check("rescan_index", 32'(index_a), 32'h0);
        k = 1;
      end
    end
    check("rescan_seen", 32'(k), 32'd1);
    repeat (12) tick();

    // ---------------- backpressure, 8 words ----------------
    ready_b = 1'b0;
    start_b = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start_b = 1'b0;
    end
    // four pushes from 00..0C, then stalled in CAPTURE on the fifth word
    check("b_busy",  32'(busy_b),  32'h1);
    check("b_addr",  32'(addr_b),  32'h10);
    check("b_valid", 32'(valid_b), 32'h1);
    check("b_head",  32'(data_b),  32'h41);
    ready_b = 1'b1;
    k = 0; ndone = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid_b) begin
        if (k < 8) begin
          check("b_data",  32'(data_b),  32'(8'h41 + 8'(k)));
          check("b_index", 32'(index_b), 32'(k));
        end
        k++;
      end
      if (done_b) ndone++;
      tick();
    end
    check("b_byte_count", 32'(k), 32'd8);
    check("b_done_count", 32'(ndone), 32'd1);

    // ---------------- address wrap from F8 ----------------
    exp_addr[0] = 8'hF8; exp_addr[1] = 8'hFC; exp_addr[2] = 8'h00;
    exp_byte[0] = 8'h7F; exp_byte[1] = 8'h80; exp_byte[2] = 8'h41;
    start_c = 1'b1;
    k = 0; na = 0; last_addr = 8'h55;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start_c = 1'b0;
      if (busy_c && addr_c != last_addr) begin
        if (na < 3) check("c_addr", 32'(addr_c), 32'(exp_addr[na]));
        na++;
        last_addr = addr_c;
      end
      if (valid_c) begin
        if (k < 3) begin
          check("c_data",  32'(data_c),  32'(exp_byte[k]));
          check("c_index", 32'(index_c), 32'(k));
        end
        k++;
      end
    end
    check("c_addr_count", 32'(na), 32'd3);
    check("c_byte_count", 32'(k), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
